// File: rtl/handshake_slice.sv
// Valid/ready register slice: bypass, forward, backward (skid) or full cut.
// Optional output transfer/stall counters are enabled by HANDSHAKE_SLICE_PERF_EN.
module handshake_slice #(
  parameter int DATA_WD = 8,
  parameter int MODE    = 3,
  parameter int CNT_WD  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [DATA_WD-1:0] data_in,
  output logic               ready_in,
  output logic               valid_out,
  output logic [DATA_WD-1:0] data_out,
  input  logic               ready_out
`ifdef HANDSHAKE_SLICE_PERF_EN
  ,
  output logic [CNT_WD-1:0]  xfer_cnt,
  output logic [CNT_WD-1:0]  stall_cnt
`endif
);

  localparam int EFF_MODE = (MODE >= 0 && MODE <= 2) ? MODE : 3;
  localparam bit USE_SKID = (EFF_MODE == 2) || (EFF_MODE == 3);
  localparam bit USE_FWD  = (EFF_MODE == 1) || (EFF_MODE == 3);

  logic               sv_q, sv_d;
  logic [DATA_WD-1:0] sd_q, sd_d;
  logic               vq_q, vq_d;
  logic [DATA_WD-1:0] dq_q, dq_d;

  logic               sk_valid;
  logic [DATA_WD-1:0] sk_data;
  logic               sk_ready_dn;
  logic               fwd_ready;
  logic               fwd_valid_in;
  logic [DATA_WD-1:0] fwd_data_in;

  always_comb begin
    sk_valid     = valid_in || sv_q;
    sk_data      = sv_q ? sd_q : data_in;
    fwd_ready    = !vq_q || ready_out;
    // In the full cut the skid stage sees the forward stage as its downstream.
    sk_ready_dn  = USE_FWD ? fwd_ready : ready_out;
    fwd_valid_in = USE_SKID ? sk_valid : valid_in;
    fwd_data_in  = USE_SKID ? sk_data : data_in;

    valid_out = USE_FWD ? vq_q : (USE_SKID ? sk_valid : valid_in);
    data_out  = USE_FWD ? dq_q : (USE_SKID ? sk_data : data_in);
    ready_in  = USE_SKID ? !sv_q : (USE_FWD ? fwd_ready : ready_out);

    sv_d = sv_q;
    sd_d = sd_q;
    if (USE_SKID) begin
      if (valid_in && !sv_q && !sk_ready_dn) begin
        sv_d = 1'b1;
        sd_d = data_in;
      end else if (sv_q && sk_ready_dn) begin
        sv_d = 1'b0;
      end
    end

    vq_d = vq_q;
    dq_d = dq_q;
    if (USE_FWD && fwd_ready) begin
      vq_d = fwd_valid_in;
      dq_d = fwd_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q <= 1'b0;
      sd_q <= '0;
      vq_q <= 1'b0;
      dq_q <= '0;
    end else begin
      sv_q <= sv_d;
      sd_q <= sd_d;
      vq_q <= vq_d;
      dq_q <= dq_d;
    end
  end

`ifdef HANDSHAKE_SLICE_PERF_EN
  logic [CNT_WD-1:0] xfer_q;
  logic [CNT_WD-1:0] stall_q;

  function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] c);
    return (&c) ? c : c + CNT_WD'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      if (valid_out && ready_out)  xfer_q  <= sat_inc(xfer_q);
      if (valid_out && !ready_out) stall_q <= sat_inc(stall_q);
    end
  end

  assign xfer_cnt  = xfer_q;
  assign stall_cnt = stall_q;
`endif

endmodule
